// File: rtl/jzjpcc_pkg.sv
// jzjpcc_pkg: shared constants and fetch packet type for the jzjpcc core
package jzjpcc_pkg;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } fetch_packet_t;
endpackage

// File: rtl/jzjpcc_fetch_skid.sv
// jzjpcc_fetch_skid: single-entry holding register for fetched instructions
module jzjpcc_fetch_skid
  import jzjpcc_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  fetch_packet_t data_in,
  output logic          valid,
  output fetch_packet_t data_out
);
  // clear beats push beats pop; a push may replace an entry only while it is popped
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      valid <= 1'b0;
      data_out <= '{instruction: NOP_INSTRUCTION, pc: 32'h0};
    end else begin
      assert (clear || !push || !valid || pop);
      if (clear) valid <= 1'b0;
      else if (push) begin
        valid <= 1'b1;
        data_out <= data_in;
      end else if (pop) valid <= 1'b0;
    end
endmodule

// File: rtl/jzjpcc_fetch_stage.sv
// jzjpcc_fetch_stage: fetch PC, imem interface, skid buffer and decode register
module jzjpcc_fetch_stage
  import jzjpcc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:2] imem_addr,
  output logic        imem_rden,
  input  logic [31:0] imem_data,
  input  logic        stall_decode,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instruction_decode,
  output logic [31:0] pc_decode,
  output logic        valid_decode
);
  logic [31:0] pc_fetch;
  logic inflight_valid;
  logic [31:0] inflight_pc;
  logic skid_valid;
  fetch_packet_t skid_packet, return_packet, decode_packet, next_packet;
  logic draining, issue, skid_push, skid_pop;
  assign draining = skid_valid && !stall_decode;
  assign issue = reset_n && !redirect && !stall_decode && (!skid_valid || draining);
  assign skid_push = inflight_valid && !redirect && (stall_decode || skid_valid);
  assign skid_pop = draining && !redirect;
  assign return_packet = '{instruction: imem_data, pc: inflight_pc};
  assign imem_addr = pc_fetch[31:2];
  assign imem_rden = issue;
  assign instruction_decode = decode_packet.instruction;
  assign pc_decode = decode_packet.pc;
  jzjpcc_fetch_skid u_skid (
    .clock(clock),
    .reset_n(reset_n),
    .push(skid_push),
    .pop(skid_pop),
    .clear(redirect),
    .data_in(return_packet),
    .valid(skid_valid),
    .data_out(skid_packet)
  );
  // oldest available instruction goes to decode; a bubble keeps the old pc
  always_comb
    next_packet = skid_valid ? skid_packet
                : inflight_valid ? return_packet
                : fetch_packet_t'{instruction: NOP_INSTRUCTION, pc: decode_packet.pc};
  // fetch pc advances on issue; the in-flight tag follows the read one cycle behind
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pc_fetch <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc <= 32'h0;
    end else begin
      inflight_valid <= issue;
      if (issue) inflight_pc <= pc_fetch;
      pc_fetch <= redirect ? (redirect_target & ~32'd3) : issue ? pc_fetch + 32'd4 : pc_fetch;
    end
  // decode register: redirect inserts a bubble, stall holds, otherwise load next
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      decode_packet <= '{instruction: NOP_INSTRUCTION, pc: 32'h0};
      valid_decode <= 1'b0;
    end else if (redirect) begin
      decode_packet.instruction <= NOP_INSTRUCTION;
      valid_decode <= 1'b0;
    end else if (!stall_decode) begin
      decode_packet <= next_packet;
      valid_decode <= skid_valid || inflight_valid;
    end
endmodule

// File: tb/tb_jzjpcc_fetch_stage.sv
// tb_jzjpcc_fetch_stage: randomized check of the fetch stage against a queue model
module tb_jzjpcc_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic stall_decode = 1'b0;
  logic redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:2] imem_addr, imem_addr2;
  logic imem_rden, imem_rden2;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] imem_data2 = 32'h0;
  logic [31:0] instruction_decode, pc_decode, instruction_decode2, pc_decode2;
  logic valid_decode, valid_decode2;
  logic [31:0] mem [256];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit first_phase = 1'b0;
  logic [31:0] m_fpc, m_ipc, m_instr;
  logic m_valid;
  logic [31:0] q [$];

  always #5 clock = ~clock;

  always @(posedge clock) if (imem_rden) imem_data <= mem[imem_addr[9:2]];
  always @(posedge clock) if (imem_rden2) imem_data2 <= mem[imem_addr2[9:2]];

  jzjpcc_fetch_stage dut (
    .clock(clock), .reset_n(reset_n), .imem_addr(imem_addr), .imem_rden(imem_rden),
    .imem_data(imem_data), .stall_decode(stall_decode), .redirect(redirect),
    .redirect_target(redirect_target), .instruction_decode(instruction_decode),
    .pc_decode(pc_decode), .valid_decode(valid_decode)
  );

  jzjpcc_fetch_stage #(.RESET_PC(RPC2)) dut2 (
    .clock(clock), .reset_n(reset_n), .imem_addr(imem_addr2), .imem_rden(imem_rden2),
    .imem_data(imem_data2), .stall_decode(stall_decode), .redirect(redirect),
    .redirect_target(redirect_target), .instruction_decode(instruction_decode2),
    .pc_decode(pc_decode2), .valid_decode(valid_decode2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic exp_rden);
    chk("rden", {31'b0, imem_rden}, {31'b0, exp_rden});
    chk("addr", {imem_addr, 2'b00}, m_fpc);
    chk("instr", instruction_decode, m_instr);
    chk("pc", pc_decode, m_ipc);
    chk("valid", {31'b0, valid_decode}, {31'b0, m_valid});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall_decode = 1'b0;
    redirect = 1'b0;
    m_fpc = 32'h0;
    m_ipc = 32'h0;
    m_instr = NOP;
    m_valid = 1'b0;
    q.delete();
    cyc = 0;
    #1;
    check_outputs(1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // one cycle: drive, check current outputs, advance the model, move to next cycle
  task automatic step(input logic st, input logic rd, input logic [31:0] tg);
    logic [31:0] p;
    stall_decode = st;
    redirect = rd;
    redirect_target = tg;
    #1;
    check_outputs(!st && !rd);
    if (first_phase && cyc < 3) chk("addr2", {imem_addr2, 2'b00}, RPC2 + 32'(4 * cyc));
    if (first_phase && cyc == 2) begin
      chk("pc2", pc_decode2, RPC2);
      chk("valid2", {31'b0, valid_decode2}, 32'd1);
    end
    if (rd) begin
      q.delete();
      m_instr = NOP;
      m_valid = 1'b0;
      m_fpc = tg & ~32'd3;
    end else if (!st) begin
      if (q.size() > 0) begin
        p = q.pop_front();
        m_ipc = p;
        m_instr = mem[p[9:2]];
        m_valid = 1'b1;
      end else begin
        m_instr = NOP;
        m_valid = 1'b0;
      end
      q.push_back(m_fpc);
      m_fpc = m_fpc + 32'd4;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    #2;
    first_phase = 1'b1;
    do_reset();
    for (int c = 0; c < 12; c++) step(c >= 5 && c <= 7, 1'b0, 32'h0);
    first_phase = 1'b0;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    do_reset();
    for (int c = 0; c < 11; c++) step(1'b0, c == 6, 32'h100);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h203);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
